// File: rtl/sdram_frame_wr_ctrl_if.sv
// Row-write handshake between the write-side frame sequencer and sdram_top,
// bundled with the write-FIFO fill level that paces the requests.
// The master side is the sequencer; the slave side is the FIFO/SDRAM side.
interface sdram_frame_wr_ctrl_if;
  logic [10:0] fifo_used;     // write-FIFO used-word count
  logic        wr_sdram_ack;  // one-cycle pulse: row burst finished
  logic        wr_sdram_req;  // row write request
  logic [23:0] wr_sdram_add;  // {1'b0, bank, row[12:0], 9'b0}

  modport master (
    input  fifo_used,
    input  wr_sdram_ack,
    output wr_sdram_req,
    output wr_sdram_add
  );

  modport slave (
    output fifo_used,
    output wr_sdram_ack,
    input  wr_sdram_req,
    input  wr_sdram_add
  );
endinterface

// File: rtl/sdram_frame_wr_ctrl.sv
// Write-side frame-buffer sequencer (clk_133M domain).
// Waits out the first camera frames after reset, then issues one burst write
// request per SDRAM row whenever the camera FIFO holds a full row, advances
// the row address, restarts on every camera VSYNC and reports frame
// completion, short frames and overdue acknowledges.
// Optional feature macro: PINGPONG_EN -- alternate between two frame banks
// after the first complete frame; when undefined a single bank (0) is
// overwritten in place.
module sdram_frame_wr_ctrl #(
  parameter int BURST_LEN   = 512,   // FIFO words needed for one row burst
  parameter int FRAME_ROWS  = 1440,  // rows per frame
  parameter int SKIP_FRAMES = 3,     // frames dropped after reset
  parameter int ACK_TIMEOUT = 4095   // cycles in request before timeout_err
) (
  input  logic                  clk_133M,
  input  logic                  rst_133,
  input  logic                  frame_tgl,
  sdram_frame_wr_ctrl_if.master bus,
  output logic [12:0]           row_cnt,
  output logic                  frame_done,
  output logic                  wr_bank,
  output logic                  timeout_err,
  output logic                  short_err
);

  localparam int SKIP_W = $clog2(SKIP_FRAMES + 1);
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [10:0]       BURST_THR = 11'(BURST_LEN);
  localparam logic [12:0]       ROWS_MAX  = 13'(FRAME_ROWS);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    S_SKIP = 2'd0,  // discarding settling frames
    S_IDLE = 2'd1,  // waiting for a full row in the FIFO
    S_REQ  = 2'd2,  // request outstanding, waiting for ack
    S_DONE = 2'd3   // frame complete, waiting for next VSYNC
  } state_e;

  state_e            state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [12:0]       row_q, row_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              bank_q, bank_d;
  logic              to_err_q, to_err_d;
  logic              short_q, short_d;
  logic              pend_q, pend_d;

  logic              sync1_q, sync2_q, sync3_q;
  logic              frame_evt;
  logic              restart;
  logic [12:0]       row_inc;

  // Bring the camera-domain VSYNC toggle across and keep one extra stage for edge detection.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_133M or negedge rst_133) begin
    if (!rst_133) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= frame_tgl;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Any change of the synchronized toggle is one new camera frame.
  assign frame_evt = sync2_q ^ sync3_q;
  assign row_inc   = row_q + 13'd1;

  // Sequencer state and all sticky status flags.
  always_ff @(posedge clk_133M or negedge rst_133) begin
    if (!rst_133) begin
      state_q  <= S_SKIP;
      skip_q   <= '0;
      row_q    <= '0;
      to_cnt_q <= '0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      bank_q   <= 1'b0;
      to_err_q <= 1'b0;
      short_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      row_q    <= row_d;
      to_cnt_q <= to_cnt_d;
      req_q    <= req_d;
      done_q   <= done_d;
      bank_q   <= bank_d;
      to_err_q <= to_err_d;
      short_q  <= short_d;
      pend_q   <= pend_d;
    end
  end

  // Next-state logic: row requests, frame restarts and the ack watchdog.
  always_comb begin
    // NOTE: every signal gets a default here first so no path can infer a latch.
    state_d  = state_q;
    skip_d   = skip_q;
    row_d    = row_q;
    to_cnt_d = '0;
    req_d    = req_q;
    done_d   = done_q;
    bank_d   = bank_q;
    to_err_d = to_err_q;
    short_d  = short_q;
    pend_d   = pend_q;
    restart  = 1'b0;

    unique case (state_q)
      S_SKIP: begin
        if (frame_evt) begin
          if (skip_q == SKIP_LAST) begin
            state_d = S_IDLE;
            row_d   = '0;
          end else begin
            skip_d = skip_q + 1'b1;
          end
        end
      end

      S_IDLE: begin
        // A new frame beats a ready row; the row is requested next cycle.
        if (frame_evt || pend_q) begin
          restart = 1'b1;
        end else if (bus.fifo_used >= BURST_THR && row_q < ROWS_MAX) begin
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // A burst in flight is never abandoned: a new frame is only remembered.
        if (frame_evt) begin
          pend_d = 1'b1;
        end
        if (bus.wr_sdram_ack) begin
          req_d = 1'b0;
          row_d = row_inc;
          if (row_inc == ROWS_MAX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
          if (to_cnt_q == TO_LAST) begin
            to_err_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        if (frame_evt || pend_q) begin
          restart = 1'b1;
        end
      end

      default: begin
        state_d = S_SKIP;
      end
    endcase

    // Start of a new frame: flag a short previous frame and rewind the row.
    if (restart) begin
      if (row_q != ROWS_MAX) begin
        short_d = 1'b1;
      end
      row_d   = '0;
      pend_d  = 1'b0;
      state_d = S_IDLE;
`ifdef PINGPONG_EN
      // Once a full frame exists the reader owns that bank; write the other.
      if (done_q) begin
        bank_d = ~bank_q;
      end
`endif
    end
  end

  assign bus.wr_sdram_req = req_q;
  assign bus.wr_sdram_add = {1'b0, bank_q, row_q, 9'd0};
  assign row_cnt          = row_q;
  assign frame_done       = done_q;
  assign wr_bank          = bank_q;
  assign timeout_err      = to_err_q;
  assign short_err        = short_q;

endmodule

// File: tb/tb_sdram_frame_wr_ctrl.sv
// Self-checking bench for sdram_frame_wr_ctrl: reset, settling-frame skip,
// a per-cycle handshake vector table, a full frame, short frames, restart
// priority corners, randomized frames against a row/bank/flag model, the
// ack watchdog and asynchronous reset. Honours PINGPONG_EN for bank checks.
module tb_sdram_frame_wr_ctrl;
  localparam int FRAME_ROWS  = 1440;
  localparam int ACK_TIMEOUT = 4095;
`ifdef PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        clk_133M = 1'b0;
  logic        rst_133;
  logic        frame_tgl;
  logic [12:0] row_cnt;
  logic        frame_done;
  logic        wr_bank;
  logic        timeout_err;
  logic        short_err;

  sdram_frame_wr_ctrl_if bus ();

  sdram_frame_wr_ctrl dut (
    .clk_133M   (clk_133M),
    .rst_133    (rst_133),
    .frame_tgl  (frame_tgl),
    .bus        (bus),
    .row_cnt    (row_cnt),
    .frame_done (frame_done),
    .wr_bank    (wr_bank),
    .timeout_err(timeout_err),
    .short_err  (short_err)
  );

  always #4 clk_133M = ~clk_133M;

  int checks = 0;
  int errors = 0;

  // Reference model: rows written this frame, bank and sticky flags.
  int m_row;
  bit m_bank;
  bit m_done;
  bit m_short;

  typedef struct {
    logic [10:0] fifo;
    logic        ack;
    logic        exp_req;
    int          exp_row;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_133M);
    #1;
  endtask

  function automatic logic [23:0] exp_add(input bit bank, input int row);
    logic [12:0] r;
    r = row[12:0];
    return {1'b0, bank, r, 9'd0};
  endfunction

  // A new frame: short if the old one was incomplete; bank flips after a full frame.
  task automatic restart_model();
    if (m_row != FRAME_ROWS) m_short = 1'b1;
    if (m_done && PP) m_bank = ~m_bank;
    m_row = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, " row_cnt"}, row_cnt, m_row);
    check({tag, " addr"}, bus.wr_sdram_add, exp_add(m_bank, m_row));
    check({tag, " frame_done"}, frame_done, m_done);
    check({tag, " wr_bank"}, wr_bank, m_bank);
    check({tag, " short_err"}, short_err, m_short);
  endtask

  // n back-to-back rows from idle: request, check address, ack, check row.
  task automatic do_rows(input int n);
    for (int i = 0; i < n; i++) begin
      bus.fifo_used = 11'd2000;
      tick();
      check("row req", bus.wr_sdram_req, 1);
      check("row addr", bus.wr_sdram_add, exp_add(m_bank, m_row));
      bus.wr_sdram_ack = 1'b1;
      bus.fifo_used    = 11'd0;
      tick();
      bus.wr_sdram_ack = 1'b0;
      m_row++;
      if (m_row == FRAME_ROWS) m_done = 1'b1;
      check("row req drop", bus.wr_sdram_req, 0);
      check("row cnt", row_cnt, m_row);
      check("row frame_done", frame_done, m_done);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, d, g;
    bit pend;

    rst_133          = 1'b0;
    frame_tgl        = 1'b0;
    bus.fifo_used    = 11'd0;
    bus.wr_sdram_ack = 1'b0;
    m_row = 0; m_bank = 0; m_done = 0; m_short = 0;

    tbl[0]  = '{11'd511,  1'b0, 1'b0, 1};
    tbl[1]  = '{11'd511,  1'b0, 1'b0, 1};
    tbl[2]  = '{11'd511,  1'b1, 1'b0, 1};  // stray ack while idle
    tbl[3]  = '{11'd512,  1'b0, 1'b1, 1};  // exactly one row -> request
    tbl[4]  = '{11'd512,  1'b0, 1'b1, 1};
    tbl[5]  = '{11'd0,    1'b0, 1'b1, 1};  // held even if FIFO drains
    tbl[6]  = '{11'd0,    1'b1, 1'b0, 2};
    tbl[7]  = '{11'd0,    1'b0, 1'b0, 2};
    tbl[8]  = '{11'd2047, 1'b0, 1'b1, 2};
    tbl[9]  = '{11'd2047, 1'b1, 1'b0, 3};
    tbl[10] = '{11'd2047, 1'b0, 1'b1, 3};  // immediate re-request
    tbl[11] = '{11'd0,    1'b1, 1'b0, 4};
    tbl[12] = '{11'd0,    1'b0, 1'b0, 4};

    // Reset state
    repeat (3) tick();
    check("reset req", bus.wr_sdram_req, 0);
    check("reset timeout", timeout_err, 0);
    check_state("reset");
    rst_133       = 1'b1;
    bus.fifo_used = 11'd600;

    // Settling frames: no request before the third frame event is taken
    for (int f = 0; f < 3; f++) begin
      frame_tgl = ~frame_tgl;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("skip no req", bus.wr_sdram_req, 0);
      end
      if (f < 2) begin
        for (int k = 0; k < 4; k++) begin
          tick();
          check("skip gap no req", bus.wr_sdram_req, 0);
        end
      end
    end
    tick();
    check("first req", bus.wr_sdram_req, 1);
    check("first addr", bus.wr_sdram_add, 24'h000000);
    bus.wr_sdram_ack = 1'b1;
    bus.fifo_used    = 11'd0;
    tick();
    bus.wr_sdram_ack = 1'b0;
    m_row = 1;
    check("first ack req", bus.wr_sdram_req, 0);
    check("first ack addr", bus.wr_sdram_add, 24'h000200);
    check_state("row1");

    // Per-cycle handshake vectors
    for (int i = 0; i < 13; i++) begin
      bus.fifo_used    = tbl[i].fifo;
      bus.wr_sdram_ack = tbl[i].ack;
      tick();
      check($sformatf("vec%0d req", i), bus.wr_sdram_req, tbl[i].exp_req);
      check($sformatf("vec%0d row", i), row_cnt, tbl[i].exp_row);
      check($sformatf("vec%0d addr", i), bus.wr_sdram_add, exp_add(1'b0, tbl[i].exp_row));
    end
    bus.wr_sdram_ack = 1'b0;
    m_row = 4;

    // Complete the frame; frame_done rises on the last ack
    do_rows(FRAME_ROWS - 4);
    check_state("frame end");
    bus.fifo_used = 11'd2000;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("done no req", bus.wr_sdram_req, 0);
    end
    bus.fifo_used = 11'd0;
    frame_tgl = ~frame_tgl;
    tick(); tick();
    check("done restart early", row_cnt, FRAME_ROWS);
    tick();
    restart_model();
    check_state("after full frame");

    // 100-row short frame; restart collides with FIFO threshold
    do_rows(100);
    frame_tgl = ~frame_tgl;
    tick(); tick();
    bus.fifo_used = 11'd600;
    tick();
    restart_model();
    check("restart beats req", bus.wr_sdram_req, 0);
    check_state("short frame");
    tick();
    check("req after restart", bus.wr_sdram_req, 1);
    check("req after restart addr", bus.wr_sdram_add, exp_add(m_bank, 0));

    // Frame event while request pending; ack 10 cycles later
    bus.fifo_used = 11'd0;
    frame_tgl = ~frame_tgl;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("pending req held", bus.wr_sdram_req, 1);
    end
    bus.wr_sdram_ack = 1'b1;
    tick();
    bus.wr_sdram_ack = 1'b0;
    m_row = 1;
    check("pending ack req", bus.wr_sdram_req, 0);
    check("pending ack row", row_cnt, 1);
    tick();
    restart_model();
    check_state("pending restart");

    // Frame event and ack on the same edge
    bus.fifo_used = 11'd600;
    tick();
    check("same-edge req", bus.wr_sdram_req, 1);
    bus.fifo_used = 11'd0;
    frame_tgl = ~frame_tgl;
    tick(); tick();
    bus.wr_sdram_ack = 1'b1;
    tick();
    bus.wr_sdram_ack = 1'b0;
    m_row = 1;
    check("same-edge ack row", row_cnt, 1);
    check("same-edge ack req", bus.wr_sdram_req, 0);
    tick();
    restart_model();
    check_state("same-edge restart");

    // Randomized frames against the model
    for (int fr = 0; fr < 6; fr++) begin
      n = $urandom_range(1, 24);
      pend = 1'b0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.fifo_used = 11'($urandom_range(0, 511));
          g = $urandom_range(1, 5);
          for (int k = 0; k < g; k++) begin
            tick();
            check("rnd below thr", bus.wr_sdram_req, 0);
          end
        end
        bus.fifo_used = 11'($urandom_range(512, 2047));
        tick();
        check("rnd req", bus.wr_sdram_req, 1);
        check("rnd addr", bus.wr_sdram_add, exp_add(m_bank, m_row));
        pend = (i == n - 1) && ($urandom_range(0, 1) == 1);
        if (pend) begin
          frame_tgl = ~frame_tgl;
          d = $urandom_range(2, 11);
        end else begin
          d = $urandom_range(0, 8);
        end
        for (int k = 0; k < d; k++) begin
          bus.fifo_used = 11'($urandom_range(0, 2047));
          tick();
          check("rnd req held", bus.wr_sdram_req, 1);
        end
        bus.wr_sdram_ack = 1'b1;
        bus.fifo_used    = 11'd0;
        tick();
        bus.wr_sdram_ack = 1'b0;
        m_row++;
        check("rnd ack req", bus.wr_sdram_req, 0);
        check("rnd ack row", row_cnt, m_row);
      end
      if (pend) begin
        tick();
      end else begin
        frame_tgl = ~frame_tgl;
        tick(); tick(); tick();
      end
      restart_model();
      check_state("rnd restart");
    end

    // Ack watchdog
    bus.fifo_used = 11'd600;
    tick();
    check("to req", bus.wr_sdram_req, 1);
    bus.fifo_used = 11'd0;
    repeat (ACK_TIMEOUT - 1) tick();
    check("to not yet", timeout_err, 0);
    tick();
    check("to set", timeout_err, 1);
    check("to req held", bus.wr_sdram_req, 1);

    // Asynchronous reset mid-burst
    #2;
    rst_133 = 1'b0;
    #1;
    m_row = 0; m_bank = 0; m_done = 0; m_short = 0;
    check("arst req", bus.wr_sdram_req, 0);
    check("arst timeout", timeout_err, 0);
    check_state("arst");
    tick();
    rst_133 = 1'b1;
    tick();
    check("post rst req", bus.wr_sdram_req, 0);
    check_state("post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
